// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline skid register slice: default payload and
// stall-counter widths, and the 2-bit occupancy state encoding used by
// pipe_skid_reg.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

  // Occupancy of the two-entry stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt
// Saturating up-counter used to count stall cycles of the skid register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear
//   inc  - add one this cycle (ignored once the count is all-ones)
//   cnt  - current count, W bits
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc and stick at all-ones instead of wrapping, so a long
  // stall can never masquerade as a short one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Two-entry pipeline register with a skid entry, so in_ready is a pure
// register and never depends combinationally on out_ready. Data leaves in
// strict FIFO order; flush kills everything held.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   flush               - synchronous kill of all held entries
//   in_valid/in_data    - upstream offer
//   in_ready            - stage can accept this cycle (registered)
//   out_valid/out_data  - downstream offer (registered)
//   out_ready           - downstream accepts (low = stall)
//   stall_cnt           - only when PIPE_SKID_STALL_CNT_EN is defined: saturating
//                         count of cycles with out_valid=1 and out_ready=0,
//                         cleared by rst only
// Optional feature macro: PIPE_SKID_STALL_CNT_EN
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_STALL_CNT_EN
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
`else
  input  logic              out_ready
`endif
);

  skid_state_t       r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_outValid;
  logic              r_inReady;

  logic              w_accept;
  logic              w_emit;
  logic [DATA_W-1:0] w_mainNext;

  // Handshakes are judged against the registered valid/ready the neighbours
  // see this cycle.
  assign w_accept = in_valid & r_inReady;
  assign w_emit   = r_outValid & out_ready;

  // The only mux on the main entry: refill from skid when draining FULL,
  // otherwise take the upstream beat.
  assign w_mainNext = (r_state == ST_FULL) ? r_skid : in_data;

  // Single FSM block owning both data entries and the registered handshake
  // outputs. rst beats flush, and flush beats every handshake, so a beat
  // accepted in a flush cycle is silently dropped. Draining to EMPTY keeps the
  // stale main value on out_data; only rst/flush zero the data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main     <= w_mainNext;
            r_state    <= ST_ONE;
            r_outValid <= 1'b1;
            r_inReady  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= w_mainNext;
          end else if (w_accept) begin
            r_skid     <= in_data;
            r_state    <= ST_FULL;
            r_inReady  <= 1'b0;
          end else if (w_emit) begin
            r_state    <= ST_EMPTY;
            r_outValid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            r_main    <= w_mainNext;
            r_state   <= ST_ONE;
            r_inReady <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_main;
  assign in_ready  = r_inReady;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic w_stall;

  // A stall is a cycle where we offer data and downstream refuses it.
  assign w_stall = r_outValid & ~out_ready;

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stallCnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall),
    .cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
// Directed self-checking bench for pipe_skid_reg. Inputs change 1 ns after a
// rising edge and outputs are checked there, well away from the next edge.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          inValid;
  logic [DW-1:0] inData;
  logic          inReady;
  logic          outValid;
  logic [DW-1:0] outData;
  logic          outReady;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stallCnt;
`endif

  int checks;
  int failures;

  pipe_skid_reg #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (inReady),
    .out_valid (outValid),
    .out_data  (outData),
`ifdef PIPE_SKID_STALL_CNT_EN
    .out_ready (outReady),
    .stall_cnt (stallCnt)
`else
    .out_ready (outReady)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; inValid = 1'b1; inData = 32'hDEADBEEF; outReady = 1'b0;
    tick();
    tick();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid); end
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady); end
    checks++;
    if (outData !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=00000000", outData); end
    rst = 1'b0; inValid = 1'b0;
    tick();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_valid got=%b exp=0", outValid); end
  endtask

  task automatic test_streaming();
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      inValid = 1'b1; inData = i;
      tick();
      checks++;
      if (outValid !== 1'b1 || outData !== DW'(i)) begin
        failures++; $display("[TB] FAIL stream_beat%0d got valid=%b data=%h exp valid=1 data=%h", i, outValid, outData, i);
      end
      checks++;
      if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready%0d got=%b exp=1", i, inReady); end
    end
    inValid = 1'b0;
    tick();
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h4) begin
      failures++; $display("[TB] FAIL stream_drain got valid=%b data=%h exp valid=0 data=00000004", outValid, outData);
    end
  endtask

  task automatic test_stall_fill();
    outReady = 1'b0; inValid = 1'b1; inData = 32'hA;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'hA || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL fill_one got valid=%b data=%h ready=%b exp 1/0000000a/1", outValid, outData, inReady);
    end
    inData = 32'hB;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'hA || inReady !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_full got valid=%b data=%h ready=%b exp 1/0000000a/0", outValid, outData, inReady);
    end
    // Offer a beat that must be refused while FULL and stalled.
    inData = 32'hEE;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'hA || inReady !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_hold got valid=%b data=%h ready=%b exp 1/0000000a/0", outValid, outData, inReady);
    end
    inValid = 1'b0; outReady = 1'b1;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'hB || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL fill_drain_b got valid=%b data=%h ready=%b exp 1/0000000b/1", outValid, outData, inReady);
    end
    tick();
    checks++;
    if (outValid !== 1'b0 || outData !== 32'hB) begin
      failures++; $display("[TB] FAIL fill_empty got valid=%b data=%h exp 0/0000000b", outValid, outData);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1; inData = 32'h11;
    tick();
    inData = 32'h22;
    tick();
    checks++;
    if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_prefull got ready=%b exp=0", inReady); end
    flush = 1'b1; inData = 32'hC;
    tick();
    flush = 1'b0; inValid = 1'b0;
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h0 || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_empty got valid=%b data=%h ready=%b exp 0/00000000/1", outValid, outData, inReady);
    end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outValid !== 1'b0 || outData === 32'hC) begin
        failures++; $display("[TB] FAIL flush_no_c%0d got valid=%b data=%h exp valid=0", i, outValid, outData);
      end
    end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1; inValid = 1'b1; inData = 32'h5;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'h5) begin
      failures++; $display("[TB] FAIL b2b_first got valid=%b data=%h exp 1/00000005", outValid, outData);
    end
    inData = 32'h6;
    tick();
    checks++;
    if (outValid !== 1'b1 || outData !== 32'h6 || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_swap got valid=%b data=%h ready=%b exp 1/00000006/1", outValid, outData, inReady);
    end
    inValid = 1'b0;
    tick();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got valid=%b exp=0", outValid); end
  endtask

  task automatic test_reset_midop();
    outReady = 1'b0; inValid = 1'b1; inData = 32'h77;
    tick();
    inData = 32'h88;
    tick();
    rst = 1'b1; inValid = 1'b0;
    tick();
    rst = 1'b0; outReady = 1'b1;
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h0 || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL midop_reset got valid=%b data=%h ready=%b exp 0/00000000/1", outValid, outData, inReady);
    end
    tick();
    checks++;
    if (outValid !== 1'b0 || outData === 32'h88) begin
      failures++; $display("[TB] FAIL midop_no_skid got valid=%b data=%h exp valid=0", outValid, outData);
    end
  endtask

`ifdef PIPE_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1'b1; tick(); rst = 1'b0;
    outReady = 1'b0; inValid = 1'b1; inData = 32'h1;
    tick();
    inValid = 1'b0;
    checks++;
    if (stallCnt !== 4'd0) begin failures++; $display("[TB] FAIL cnt_start got=%0d exp=0", stallCnt); end
    tick(); tick(); tick();
    checks++;
    if (stallCnt !== 4'd3) begin failures++; $display("[TB] FAIL cnt_three got=%0d exp=3", stallCnt); end
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (stallCnt !== 4'd15) begin failures++; $display("[TB] FAIL cnt_sat got=%0d exp=15", stallCnt); end
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    checks++;
    if (stallCnt !== 4'd15) begin failures++; $display("[TB] FAIL cnt_flush got=%0d exp=15", stallCnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (stallCnt !== 4'd0) begin failures++; $display("[TB] FAIL cnt_reset got=%0d exp=0", stallCnt); end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_back_to_back();
    test_reset_midop();
`ifdef PIPE_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (minimum 1).
REQ-002 Parameter CNT_W, default 16, stall-counter width (used only under REQ-030).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous kill of all held entries (branch or exception bubble).
REQ-006 Port in_valid  input  1  upstream offers in_data this cycle.
REQ-007 Port in_data  input  DATA_W  upstream payload.
REQ-008 Port in_ready  output  1  stage can accept this cycle; driven from a register, never combinationally from out_ready.
REQ-009 Port out_valid  output  1  out_data is valid this cycle.
REQ-010 Port out_data  output  DATA_W  payload to downstream, driven from a register.
REQ-011 Port out_ready  input  1  downstream accepts this cycle (deasserted = stall).

Function
REQ-012 Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated at the same rising edge.
REQ-013 Storage: main entry (drives out_data) plus one skid entry; two-entry capacity.
REQ-014 States: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), FULL (out_valid=1, in_ready=0).
REQ-015 EMPTY: accept -> ONE with main<=in_data; otherwise stay.
REQ-016 ONE: accept & emit -> ONE with main<=in_data; accept & !emit -> FULL with skid<=in_data; !accept & emit -> EMPTY; neither -> ONE, hold.
REQ-017 FULL: emit -> ONE with main<=skid; !emit -> FULL, hold both entries; no accept is possible.
REQ-018 Latency: accepted data appears on out_data the cycle after acceptance; throughput is one transfer per cycle with out_ready held high.
REQ-019 Ordering: strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-020 Flush: next state EMPTY, main and skid cleared to 0, in_ready=1; a beat accepted in the flush cycle is discarded; flush overrides every REQ-015..017 transition.
REQ-021 Drain to EMPTY (REQ-016 emit path) leaves out_data at its last value with out_valid=0; only reset or flush zeroes data.
REQ-022 out_valid and out_data remain stable while out_valid=1 and out_ready=0.

Reset
REQ-023 rst has priority over flush and all handshakes.
REQ-024 Reset values: state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0, stall counter=0.
REQ-025 Reset asserted mid-operation (ONE or FULL) discards all held entries at that edge.

Configuration
REQ-030 Macro PIPE_SKID_STALL_CNT_EN: when defined, the module adds output stall_cnt (CNT_W) counting cycles with out_valid=1 and out_ready=0.
REQ-031 With PIPE_SKID_STALL_CNT_EN defined, stall_cnt saturates at all-ones, is cleared by rst only (not by flush), and updates one cycle after the counted cycle.
REQ-032 Without PIPE_SKID_STALL_CNT_EN, the stall_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package pipe_pkg holds the state encoding (EMPTY/ONE/FULL, 2-bit) and the default widths DATA_W=32 and CNT_W=16.
REQ-034 The stall counter is implemented as sub-module pipe_sat_cnt (parameter W; inputs clk, rst, inc; output cnt), instantiated only under PIPE_SKID_STALL_CNT_EN.
REQ-035 No other sub-modules; the datapath is two DATA_W registers plus one 2:1 mux on the main-entry load.

Verification
REQ-040 Reset: rst=1 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF -> out_valid=0, in_ready=1, out_data=0.
REQ-041 Streaming: out_ready=1, in_data=1,2,3,4 over consecutive cycles -> out_data=1,2,3,4 one cycle later, in_ready stays 1.
REQ-042 Stall fill: send 0xA then 0xB with out_ready=0 -> FULL, in_ready=0, out_data=0xA held; raise out_ready -> outputs 0xA, then 0xB, then EMPTY.
REQ-043 Flush in FULL with in_valid=1 and in_data=0xC -> next cycle EMPTY, out_valid=0, out_data=0, 0xC never emitted.
REQ-044 Simultaneous accept and emit in ONE (main=5, in_data=6) -> out_data=6 next cycle, state ONE.
REQ-045 With PIPE_SKID_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush leaves 15; rst gives 0.
